control_unit: RTL and testbench

Fetch/decode/execute controller for the mini CPU, sitting directly upstream of the instruction ROM and downstream of its data output. Owns the program counter, drives the ROM address, latches the returned 8-bit instruction into an instruction register (IR), and decodes it. Issues register-file read and write controls and data-memory store controls. The register file, ROM and data memory are external.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/alu_add.sv | 13 +
 rtl/control_unit.sv | 117 +++++++++++
 tb/tb_control_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA and FSM definitions for the mini CPU control path.
package cpu_pkg;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_HALT  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam logic [7:0] INSTR_NOP = 8'h00;

    // IR field bit positions
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS1_HI = 3;
    localparam int RS1_LO = 2;
    localparam int RS2_HI = 1;
    localparam int RS2_LO = 0;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

endpackage

// File: rtl/alu_add.sv
// Unsigned adder producing the wrapped sum and the carry out of the top bit.
module alu_add #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute controller: owns PC and IR, issues register-file and
// data-memory controls. Each instruction takes FETCH, DECODE, EXECUTE.
module control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4,
    parameter int HALT_ON_WRAP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] pc_addr,
    input  logic [7:0]        instr,
    output logic [1:0]        rf_raddr_a,
    output logic [1:0]        rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [1:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              carry,
    output logic              halted
);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        ir_q;
    logic              carry_q;
    logic              halted_q;
    logic              rf_we_q;
    logic              dmem_we_q;
    logic [1:0]        raddr_a_q;
    logic [1:0]        raddr_b_q;

    logic [1:0]        ir_op;
    logic [1:0]        in_op;
    logic [3:0]        ir_imm;
    logic [DATA_W-1:0] sum;
    logic              sum_carry;
    logic              wrap_blocked;

    assign ir_op  = ir_q[OP_HI:OP_LO];
    assign in_op  = instr[OP_HI:OP_LO];
    assign ir_imm = ir_q[IMM_HI:IMM_LO];

    alu_add #(.DATA_W(DATA_W)) u_alu (
        .a_i    (rf_rdata_a),
        .b_i    (rf_rdata_b),
        .sum_o  (sum),
        .carry_o(sum_carry)
    );

    assign wrap_blocked = (HALT_ON_WRAP != 0) && (pc_q == '1);

    // Strobes come straight from flops so reset kills them without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= INSTR_NOP;
            carry_q   <= 1'b0;
            halted_q  <= 1'b0;
            rf_we_q   <= 1'b0;
            dmem_we_q <= 1'b0;
            raddr_a_q <= 2'd0;
            raddr_b_q <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    ir_q      <= instr;
                    raddr_a_q <= (in_op == OP_STORE) ? instr[RD_HI:RD_LO] : instr[RS1_HI:RS1_LO];
                    raddr_b_q <= instr[RS2_HI:RS2_LO];
                    state_q   <= S_DECODE;
                end
                S_DECODE: begin
                    rf_we_q   <= ((ir_op == OP_LOADI) && (ir_q != INSTR_NOP)) || (ir_op == OP_ADD);
                    dmem_we_q <= (ir_op == OP_STORE);
                    state_q   <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    rf_we_q   <= 1'b0;
                    dmem_we_q <= 1'b0;
                    if (ir_op == OP_ADD) carry_q <= sum_carry;
                    if ((ir_op == OP_HALT) || wrap_blocked) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q    <= pc_q + ADDR_W'(1);
                        state_q <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pc_addr    = pc_q;
    assign rf_raddr_a = raddr_a_q;
    assign rf_raddr_b = raddr_b_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = ir_q[RD_HI:RD_LO];
    assign rf_wdata   = (ir_op == OP_ADD) ? sum : DATA_W'(ir_imm);
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = ADDR_W'(ir_q[IMM_HI:IMM_LO]);
    assign dmem_wdata = rf_rdata_a;
    assign carry      = carry_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: ROM/regfile/dmem models around the DUT, strobe
// scoreboard checked by a negedge monitor, plus a HALT_ON_WRAP=1 instance.
module tb_control_unit;

    localparam int DW = 8;
    localparam int AW = 4;

    typedef struct {
        bit is_mem;
        int cyc;
        int addr;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] pc_addr, dmem_addr;
    logic [7:0]    instr;
    logic [1:0]    rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [DW-1:0] rf_rdata_a, rf_rdata_b, rf_wdata, dmem_wdata;
    logic          rf_we, dmem_we, carry, halted;

    logic [AW-1:0] pc1, dmem_addr1;
    logic [1:0]    raddr_a1, raddr_b1, waddr1;
    logic [DW-1:0] wdata1, dmem_wdata1;
    logic          rf_we1, dmem_we1, carry1, halted1;

    logic [7:0]    rom [16];
    logic [DW-1:0] regs [4];
    logic [DW-1:0] dmem [16];
    logic          pre_we = 1'b0;
    logic [1:0]    pre_addr = 2'd0;
    logic [DW-1:0] pre_data = '0;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   F = 0;

    control_unit #(.DATA_W(DW), .ADDR_W(AW), .HALT_ON_WRAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .pc_addr(pc_addr), .instr(instr),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .carry(carry), .halted(halted)
    );

    control_unit #(.DATA_W(DW), .ADDR_W(AW), .HALT_ON_WRAP(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .run(run), .pc_addr(pc1), .instr(8'h00),
        .rf_raddr_a(raddr_a1), .rf_raddr_b(raddr_b1),
        .rf_rdata_a(8'h00), .rf_rdata_b(8'h00),
        .rf_we(rf_we1), .rf_waddr(waddr1), .rf_wdata(wdata1),
        .dmem_we(dmem_we1), .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1),
        .carry(carry1), .halted(halted1)
    );

    assign instr      = rom[pc_addr];
    assign rf_rdata_a = regs[rf_raddr_a];
    assign rf_rdata_b = regs[rf_raddr_b];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pre_we) regs[pre_addr] <= pre_data;
        else if (rf_we) regs[rf_waddr] <= rf_wdata;
        if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    // Every strobe must match the oldest expected event, including its cycle.
    always @(negedge clk) begin
        if (rst_n && (rf_we || dmem_we)) begin
            exp_t e;
            int ga, gd;
            n_cmp++;
            ga = dmem_we ? int'(dmem_addr) : int'(rf_waddr);
            gd = dmem_we ? int'(dmem_wdata) : int'(rf_wdata);
            if (rf_we && dmem_we) begin
                n_bad++;
                $display("FAIL dual_strobe: both strobes high at cycle %0d, required one", cyc);
            end else if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: mem=%0b addr=%0d data=%0d at cycle %0d, required none",
                         dmem_we, ga, gd, cyc);
            end else begin
                e = sbq.pop_front();
                if (dmem_we !== e.is_mem || cyc != e.cyc || ga != e.addr || gd != e.data) begin
                    n_bad++;
                    $display("FAIL strobe: got mem=%0b cyc=%0d addr=%0d data=%0d, required mem=%0b cyc=%0d addr=%0d data=%0d",
                             dmem_we, cyc, ga, gd, e.is_mem, e.cyc, e.addr, e.data);
                end
            end
        end
        if (rst_n && (rf_we1 || dmem_we1)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wrap_strobe: NOP-only instance strobed at cycle %0d, required none", cyc);
        end
    end

    task automatic push(input bit m, input int c, input int a, input int d);
        exp_t e;
        e.is_mem = m; e.cyc = c; e.addr = a; e.data = d;
        sbq.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic rom_nops();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic rom_default();
        rom_nops();
        rom[0] = 8'h05; rom[1] = 8'h13; rom[2] = 8'h61; rom[3] = 8'hE4;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0; run = 1'b0;
        sbq.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic preload(input logic [1:0] a, input logic [DW-1:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(posedge clk); #1 pre_we = 1'b0;
    endtask

    // Releases reset, raises run; F is the first FETCH cycle.
    task automatic start();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        F = cyc;
    endtask

    task automatic test_reset();
        @(posedge clk); #1 rst_n = 1'b0; run = 1'b0;
        #1;
        n_cmp++; if (pc_addr !== 4'd0) begin n_bad++; $display("FAIL reset_pc: got %0d, required 0", pc_addr); end
        n_cmp++; if (rf_we !== 1'b0 || dmem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b%b, required 00", rf_we, dmem_we); end
        n_cmp++; if (halted !== 1'b0 || carry !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got halted=%b carry=%b, required 0 0", halted, carry); end
        n_cmp++; if (rf_raddr_a !== 2'd0 || rf_raddr_b !== 2'd0) begin n_bad++; $display("FAIL reset_raddr: got %0d %0d, required 0 0", rf_raddr_a, rf_raddr_b); end
    endtask

    task automatic test_default_program();
        rom_default();
        do_reset();
        start();
        push(0, F+2, 0, 5); push(0, F+5, 1, 3); push(0, F+8, 2, 8); push(1, F+11, 4, 8);
        n_cmp++; if (pc_addr !== 4'd0) begin n_bad++; $display("FAIL first_fetch_pc: got %0d, required 0", pc_addr); end
        goto(F+8);
        n_cmp++; if (carry !== 1'b0) begin n_bad++; $display("FAIL add_carry_exec: got %b, required 0", carry); end
        goto(F+12);
        n_cmp++; if (dmem[4] !== 8'd8) begin n_bad++; $display("FAIL dmem4: got %0d, required 8", dmem[4]); end
        n_cmp++; if (regs[2] !== 8'd8) begin n_bad++; $display("FAIL r2: got %0d, required 8", regs[2]); end
        n_cmp++; if (carry !== 1'b0) begin n_bad++; $display("FAIL carry_after_add: got %b, required 0", carry); end
        goto(F+47);
        n_cmp++; if (pc_addr !== 4'd15) begin n_bad++; $display("FAIL pc_last: got %0d, required 15", pc_addr); end
        goto(F+48);
        n_cmp++; if (pc_addr !== 4'd0) begin n_bad++; $display("FAIL pc_wrap: got %0d, required 0", pc_addr); end
        n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL default_pending: got %0d left, required 0", sbq.size()); end
    endtask

    task automatic test_add_overflow();
        rom_nops();
        rom[0] = 8'h61;
        do_reset();
        preload(2'd0, 8'd200);
        preload(2'd1, 8'd100);
        start();
        push(0, F+2, 2, 44);
        goto(F+3);
        n_cmp++; if (carry !== 1'b1) begin n_bad++; $display("FAIL ovf_carry: got %b, required 1", carry); end
        goto(F+10);
        n_cmp++; if (carry !== 1'b1) begin n_bad++; $display("FAIL carry_sticky: got %b, required 1", carry); end
        n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL ovf_pending: got %0d left, required 0", sbq.size()); end
    endtask

    task automatic test_halt();
        rom_nops();
        rom[0] = 8'h05; rom[1] = 8'h13; rom[2] = 8'h80; rom[3] = 8'h37;
        do_reset();
        start();
        push(0, F+2, 0, 5); push(0, F+5, 1, 3);
        goto(F+8);
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_early: got %b, required 0", halted); end
        goto(F+9);
        n_cmp++; if (halted !== 1'b1 || pc_addr !== 4'd2) begin n_bad++; $display("FAIL halt_entry: got halted=%b pc=%0d, required 1 2", halted, pc_addr); end
        goto(F+29);
        n_cmp++; if (halted !== 1'b1 || pc_addr !== 4'd2) begin n_bad++; $display("FAIL halt_hold: got halted=%b pc=%0d, required 1 2", halted, pc_addr); end
        n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL halt_pending: got %0d left, required 0", sbq.size()); end
    endtask

    task automatic test_run_drop();
        rom_default();
        do_reset();
        start();
        push(0, F+2, 0, 5); push(0, F+5, 1, 3);
        goto(F+4);
        run = 1'b0;
        goto(F+6);
        n_cmp++; if (pc_addr !== 4'd2) begin n_bad++; $display("FAIL park_pc: got %0d, required 2", pc_addr); end
        goto(F+10);
        n_cmp++; if (pc_addr !== 4'd2) begin n_bad++; $display("FAIL park_hold: got %0d, required 2", pc_addr); end
        run = 1'b1;
        push(0, F+13, 2, 8); push(1, F+16, 4, 8);
        goto(F+11);
        n_cmp++; if (pc_addr !== 4'd2) begin n_bad++; $display("FAIL resume_pc: got %0d, required 2", pc_addr); end
        goto(F+17);
        n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL resume_pending: got %0d left, required 0", sbq.size()); end
    endtask

    task automatic test_reset_mid_store();
        rom_default();
        do_reset();
        start();
        push(0, F+2, 0, 5); push(0, F+5, 1, 3); push(0, F+8, 2, 8);
        goto(F+10);
        @(posedge clk); #1;
        n_cmp++; if (dmem_we !== 1'b1) begin n_bad++; $display("FAIL store_exec: got %b, required 1", dmem_we); end
        #1 rst_n = 1'b0; run = 1'b0;
        #1;
        n_cmp++; if (dmem_we !== 1'b0) begin n_bad++; $display("FAIL async_kill: got %b, required 0", dmem_we); end
        n_cmp++; if (pc_addr !== 4'd0 || halted !== 1'b0) begin n_bad++; $display("FAIL async_state: got pc=%0d halted=%b, required 0 0", pc_addr, halted); end
        n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL prereset_pending: got %0d left, required 0", sbq.size()); end
        start();
        push(0, F+2, 0, 5);
        n_cmp++; if (pc_addr !== 4'd0) begin n_bad++; $display("FAIL restart_pc: got %0d, required 0", pc_addr); end
        goto(F+4);
        n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL restart_pending: got %0d left, required 0", sbq.size()); end
    endtask

    task automatic test_halt_on_wrap();
        rom_nops();
        do_reset();
        start();
        goto(F+47);
        n_cmp++; if (pc1 !== 4'd15 || halted1 !== 1'b0) begin n_bad++; $display("FAIL wrap_last: got pc=%0d halted=%b, required 15 0", pc1, halted1); end
        goto(F+48);
        n_cmp++; if (pc1 !== 4'd15 || halted1 !== 1'b1) begin n_bad++; $display("FAIL wrap_halt: got pc=%0d halted=%b, required 15 1", pc1, halted1); end
        n_cmp++; if (pc_addr !== 4'd0 || halted !== 1'b0) begin n_bad++; $display("FAIL nowrap_ref: got pc=%0d halted=%b, required 0 0", pc_addr, halted); end
        goto(F+56);
        n_cmp++; if (pc1 !== 4'd15 || halted1 !== 1'b1) begin n_bad++; $display("FAIL wrap_hold: got pc=%0d halted=%b, required 15 1", pc1, halted1); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) regs[i] = '0;
        for (int i = 0; i < 16; i++) dmem[i] = '0;
        rom_nops();
        test_reset();
        test_default_program();
        test_add_overflow();
        test_halt();
        test_run_drop();
        test_reset_mid_store();
        test_halt_on_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
